// File: rtl/delay_aligner.sv
// delay_aligner: measures the latency of an external chain from a marker pulse
// (mark_in -> mark_out) and delays the side stream I by that latency so O stays
// sample-aligned with the chain output.
module delay_aligner #(
  parameter int WIDTH     = 16,
  parameter int MAX_DELAY = 64,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mark_in,
  input  logic             mark_out,
  input  logic [WIDTH-1:0] I,
  output logic [WIDTH-1:0] O,
  output logic [DW-1:0]    delay,
  output logic             locked,
  output logic             timeout
);

  // Pointer width for the MAX_DELAY-entry circular line (at least one bit).
  localparam int AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  // One extra bit so wr_ptr + MAX_DELAY - delay cannot overflow.
  localparam int SW = DW + 1;

  localparam logic [DW-1:0] MAX_CNT  = DW'(MAX_DELAY);
  localparam logic [AW-1:0] LAST_PTR = AW'(MAX_DELAY - 1);
  localparam logic [SW-1:0] DEPTH_S  = SW'(MAX_DELAY);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [DW-1:0]    cnt_r;
  logic [DW-1:0]    cnt_nxt_s;
  logic [DW-1:0]    delay_r;
  logic [DW-1:0]    delay_nxt_s;
  logic             locked_r;
  logic             locked_nxt_s;
  logic             timeout_r;
  logic             timeout_nxt_s;

  logic [WIDTH-1:0] mem_r [MAX_DELAY];
  logic [AW-1:0]    wr_ptr_r;
  logic [SW-1:0]    rd_sum_s;
  logic [AW-1:0]    rd_ptr_s;

  // Delay-line storage: every sample is captured, even while in reset.
  always_ff @(posedge clk) begin
    mem_r[wr_ptr_r] <= I;
  end

  // Circular write pointer over MAX_DELAY entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
    end else if (wr_ptr_r == LAST_PTR) begin
      wr_ptr_r <= {AW{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + AW'(1);
    end
  end

  // Read tap: the slot written `delay` cycles ago; delay == MAX_DELAY reads the
  // slot about to be overwritten this cycle, which still holds I(t-MAX_DELAY).
  always_comb begin
    rd_sum_s = SW'(wr_ptr_r) + DEPTH_S - SW'(delay_r);
    if (rd_sum_s >= DEPTH_S) begin
      rd_ptr_s = AW'(rd_sum_s - DEPTH_S);
    end else begin
      rd_ptr_s = AW'(rd_sum_s);
    end
  end

  // Zero delay bypasses the line so O follows I in the same cycle.
  assign O = (delay_r == {DW{1'b0}}) ? I : mem_r[rd_ptr_s];

  // FSM state and measurement registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {DW{1'b0}};
      delay_r   <= {DW{1'b0}};
      locked_r  <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      delay_r   <= delay_nxt_s;
      locked_r  <= locked_nxt_s;
      timeout_r <= timeout_nxt_s;
    end
  end

  // Next-state logic; start overrides any marker in the same cycle.
  always_comb begin
    state_nxt_s = state_r;
    if (start) begin
      state_nxt_s = ST_ARMED;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_ARMED: begin
          if (mark_in && mark_out) begin
            state_nxt_s = ST_LOCKED;
          end else if (mark_in) begin
            state_nxt_s = ST_MEASURE;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_MEASURE: begin
          if (mark_out) begin
            state_nxt_s = ST_LOCKED;
          end else if (cnt_r == MAX_CNT) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_MEASURE;
          end
        end
        ST_LOCKED: begin
          state_nxt_s = ST_LOCKED;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Counter, delay and status updates; delay only changes on a completed lock.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    delay_nxt_s   = delay_r;
    locked_nxt_s  = locked_r;
    timeout_nxt_s = timeout_r;
    if (start) begin
      cnt_nxt_s     = {DW{1'b0}};
      locked_nxt_s  = 1'b0;
      timeout_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_ARMED: begin
          if (mark_in && mark_out) begin
            delay_nxt_s  = {DW{1'b0}};
            locked_nxt_s = 1'b1;
          end else if (mark_in) begin
            cnt_nxt_s = DW'(1);
          end else begin
            cnt_nxt_s = cnt_r;
          end
        end
        ST_MEASURE: begin
          if (mark_out) begin
            delay_nxt_s  = cnt_r;
            locked_nxt_s = 1'b1;
          end else if (cnt_r == MAX_CNT) begin
            timeout_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + DW'(1);
          end
        end
        ST_IDLE, ST_LOCKED: begin
          cnt_nxt_s = cnt_r;
        end
        default: begin
          cnt_nxt_s     = {DW{1'b0}};
          delay_nxt_s   = {DW{1'b0}};
          locked_nxt_s  = 1'b0;
          timeout_nxt_s = 1'b0;
        end
      endcase
    end
  end

  assign delay   = delay_r;
  assign locked  = locked_r;
  assign timeout = timeout_r;

endmodule
